spi_reg_master: RTL and testbench
=================================

# spi_reg_master

SPI initiator for the register-access protocol spoken by our SPI register target. Converts a single-cycle start request (read or write, address, data) into one 16-bit mode-0 frame: command byte `{rw, 0…, addr}` then data byte, MSB first. Used in the test harness and in-chip to drive register slaves from the system clock domain; all SPI signals are generated from `clk`.

## Interface

- `ADDR_W`, 3, register address width (≤7).
- `REG_W`, 8, data width; fixed at 8 by protocol.
- `CLK_DIV`, 4, clk cycles per SPI half period; must be ≥4 so the target's edge detectors and FSM settle between edges.
- `CS_GAP`, 8, clk cycles spi_cs_n held high after a frame before done; ≥4.

- `clk` in 1 system clock.
- `rstb` in 1 reset, synchronous, active-low.
- `ena` in 1 global enable; when low every register holds its value.
- `start` in 1 request pulse; sampled only when idle.
- `rw` in 1 1 = write, 0 = read.
- `addr` in ADDR_W target register address.
- `wdata` in REG_W write data.
- `busy` out 1 high from the cycle after start is accepted until done.
- `done` out 1 one-cycle pulse at end of transaction.
- `rdata` out REG_W read data; valid at done after a read, held until the next read completes.
- `spi_clk` out 1 SPI clock, idle low (CPOL=0).
- `spi_cs_n` out 1 chip select, active low.
- `spi_mosi` out 1 serial data to target.
- `spi_miso` in 1 serial data from target.

## Operation

- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: `start`=1 with `ena`=1 latches `rw`, `addr`, `wdata` into a 16-bit shift register `{rw, zero pad, addr, rw ? wdata : 0}` → SETUP. `start` in other states is ignored.
- SETUP: cs_n=0, mosi=bit15, spi_clk=0; after CLK_DIV cycles → SHIFT.
- SHIFT: half-period counter toggles spi_clk every CLK_DIV cycles. On each rising edge, spi_miso is shifted into the read register on the cycle spi_clk goes high; only edges 9–16 are retained as rdata. On each falling edge, shift register shifts left and mosi presents the next bit. After the 16th falling edge → HOLD.
- HOLD: spi_clk=0, cs_n=0 for CLK_DIV cycles, then cs_n=1 → GAP.
- GAP: cs_n=1 for CS_GAP cycles → IDLE, with done=1 and busy=0 in the first IDLE cycle. rdata is updated there only if rw=0.
- A bit counter of 5 bits and a half-period counter of $clog2(CLK_DIV) bits; both clear on frame start.
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rdata=0, state IDLE.
- Reset mid-frame: next cycle all outputs are at reset values and the target sees cs_n rise (abort). No done.
- ena low mid-frame: spi_clk, cs_n, and the counters freeze. Frame resumes unchanged when ena returns.

## Timing

- Start accepted at cycle 0. cs_n falls and busy rises at cycle 1.
- Rising edge k (1..16) at cycle 1+(2k−1)·CLK_DIV; falling edge k at 1+2k·CLK_DIV.
- cs_n rises at 1+33·CLK_DIV. done pulses at 1+33·CLK_DIV+CS_GAP. Defaults: 133 and 141.
- A new start is accepted in the done cycle. Back-to-back period is 1+33·CLK_DIV+CS_GAP cycles.
- mosi is stable a full SPI period around each rising edge. miso is sampled half a period after the target's falling-edge update.

## Structure

- Shared package `spi_reg_pkg`:
  - state enum `spi_master_state_t`
  - `SPI_FRAME_BITS`=16
  - `SPI_RW_BIT`=7
  - `SPI_MIN_CLK_DIV`=4
- Optional sub-module `spi_tick_gen` (half-period counter producing rise/fall strikes). Everything else stays in one module.

## Test plan

- Write: rw=1, addr=5, wdata=0xA5 into a target instance. MOSI bits are 0x85 then 0xA5; target asserts reg_data_o_dv with 0xA5, reg_addr=5; done at cycle 141.
- Read: rw=0, addr=3, target reg_data_i=0x3C. Target reg_data_o_dv stays 0; rdata=0x3C at done; busy low in that cycle.
- Protocol check: 16 spi_clk rising edges per frame, cs_n low cycles 1..132; start pulsed while busy is ignored (no second frame, no extra done).
- ena held low for 20 cycles mid-SHIFT: spi_clk/cs_n frozen. Transaction still completes correctly, with done delayed by 20.
- rstb low during bit 10: next cycle cs_n=1, spi_clk=0, busy=0, no done. The following read of addr 2 (0x5A) returns 0x5A.
- Back-to-back: start in done cycle (write 0x11 addr 1, then read addr 1). Second cs_n falls one cycle after done and rdata=0x11.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access master.
// A frame is the command byte {rw, addr} followed by one data byte.
package spi_reg_pkg;

  localparam int SPI_FRAME_BITS  = 16;
  localparam int SPI_RW_BIT      = 7;
  localparam int SPI_MIN_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_master_state_t;

  // Reads send a zero data byte so the target never sees stale write data.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
    input logic                  rw,
    input logic [SPI_RW_BIT-1:0] addr,
    input logic [7:0]            wdata
  );
    return {rw, addr, (rw ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer for the SPI master: strikes once every CLK_DIV enabled
// cycles while running, restarting from zero on clr.
module spi_tick_gen
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic clr,
  input  logic run,
  output logic tick
);

  // The target's edge detectors need a minimum half period to settle.
  localparam int DIV   = (CLK_DIV < SPI_MIN_CLK_DIV) ? SPI_MIN_CLK_DIV : CLK_DIV;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr || tick) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// Mode-0 SPI initiator issuing one 16-bit register read or write per start.
// state | meaning
// IDLE  | waiting for start; done pulses here at the end of a transaction
// SETUP | cs_n low, first bit on mosi, spi_clk low for one half period
// SHIFT | 16 spi_clk periods; sample miso on rise, shift mosi on fall
// HOLD  | spi_clk low, cs_n still low for one half period
// GAP   | cs_n high for CS_GAP cycles before reporting done
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  rdata,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int         GAP_W    = $clog2(CS_GAP);
  localparam logic [4:0] LAST_BIT = 5'(SPI_FRAME_BITS - 1);
  localparam logic [4:0] RX_FIRST = 5'(SPI_FRAME_BITS - REG_W);

  spi_master_state_t         state, state_nxt;
  logic [SPI_FRAME_BITS-1:0] frame, sreg;
  logic [REG_W-1:0]          rx_sreg;
  logic [4:0]                bit_cnt;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      rw_q;
  logic                      tick, tick_run;
  logic                      load, rise, fall, gap_clr, finish;

  assign frame    = spi_frame(rw, SPI_RW_BIT'(addr), wdata);
  assign tick_run = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .clr  (load),
    .run  (tick_run),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    gap_clr   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          rise      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (spi_clk) begin
            fall = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = ST_HOLD;
            end
          end else begin
            rise = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          gap_clr   = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sreg     <= '0;
      rx_sreg  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      rw_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      spi_clk  <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else if (ena) begin
      done <= finish;
      if (load) begin
        sreg     <= frame;
        rw_q     <= rw;
        rx_sreg  <= '0;
        bit_cnt  <= '0;
        spi_mosi <= frame[SPI_FRAME_BITS-1];
        spi_cs_n <= 1'b0;
        busy     <= 1'b1;
      end
      // Only the data-phase bits land in the read register.
      if (rise) begin
        spi_clk <= 1'b1;
        if (bit_cnt >= RX_FIRST) begin
          rx_sreg <= {rx_sreg[REG_W-2:0], spi_miso};
        end
      end
      if (fall) begin
        spi_clk  <= 1'b0;
        sreg     <= {sreg[SPI_FRAME_BITS-2:0], 1'b0};
        spi_mosi <= sreg[SPI_FRAME_BITS-2];
        bit_cnt  <= bit_cnt + 5'd1;
      end
      if (gap_clr) begin
        spi_cs_n <= 1'b1;
        gap_cnt  <= '0;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
      if (finish) begin
        busy <= 1'b0;
        if (!rw_q) begin
          rdata <= rx_sreg;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master with a behavioural SPI register target and a
// scoreboard of expected transaction completions.
module tb_spi_reg_master;

  localparam int ADDR_W   = 3;
  localparam int REG_W    = 8;
  localparam int CLK_DIV  = 4;
  localparam int CS_GAP   = 8;
  localparam int CS_RISE  = 1 + 33 * CLK_DIV;
  localparam int DONE_LAT = CS_RISE + CS_GAP;

  logic              clk   = 1'b0;
  logic              rstb  = 1'b0;
  logic              ena   = 1'b1;
  logic              start = 1'b0;
  logic              rw    = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic [REG_W-1:0]  wdata = '0;
  logic              busy, done, spi_clk, spi_cs_n, spi_mosi;
  logic [REG_W-1:0]  rdata;
  logic              spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_reg_master #(
    .ADDR_W  (ADDR_W),
    .REG_W   (REG_W),
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  typedef struct {
    int unsigned acc;
    int unsigned delay;
    logic [7:0]  rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int unsigned edge_n   = 0;

  always @(posedge clk) edge_n++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural register target: mode 0, captures mosi on rise, drives miso on fall.
  logic [7:0]  tgt_regs [8] = '{8'h00, 8'h00, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [15:0] tgt_sh    = '0;
  logic [15:0] tgt_last  = '0;
  logic [7:0]  tgt_tx    = '0;
  logic        tgt_clk_q = 1'b0;
  logic        tgt_cs_q  = 1'b1;
  int          tgt_cnt   = 0;
  int          tgt_edges = 0;
  int          tgt_frames = 0;
  int          tgt_wr    = 0;

  always @(spi_clk or spi_cs_n) begin
    if (tgt_cs_q === 1'b1 && spi_cs_n === 1'b0) begin
      tgt_cnt  = 0;
      spi_miso = 1'b0;
    end
    if (tgt_cs_q === 1'b0 && spi_cs_n === 1'b1) begin
      tgt_edges = tgt_cnt;
      if (tgt_cnt == 16) begin
        tgt_frames++;
        tgt_last = tgt_sh;
        if (tgt_sh[15]) begin
          tgt_regs[tgt_sh[10:8]] = tgt_sh[7:0];
          tgt_wr++;
        end
      end
    end
    if (spi_cs_n === 1'b0 && tgt_clk_q === 1'b0 && spi_clk === 1'b1) begin
      tgt_sh = {tgt_sh[14:0], spi_mosi};
      tgt_cnt++;
      if (tgt_cnt == 8) tgt_tx = tgt_regs[tgt_sh[2:0]];
    end
    if (spi_cs_n === 1'b0 && tgt_clk_q === 1'b1 && spi_clk === 1'b0) begin
      if (tgt_cnt >= 8 && tgt_cnt < 16) spi_miso = tgt_tx[15 - tgt_cnt];
    end
    tgt_clk_q = spi_clk;
    tgt_cs_q  = spi_cs_n;
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("spurious_done", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("done_cycle", edge_n, mon_e.acc + DONE_LAT + mon_e.delay);
        check("rdata_at_done", rdata, mon_e.rdata);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  // Called on a negedge; that cycle becomes cycle 0 of the transaction.
  task automatic do_start(input logic r, input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int unsigned dly,
                          input bit track, output int unsigned acc);
    exp_t e;
    rw    = r;
    addr  = a;
    wdata = d;
    start = 1'b1;
    acc   = edge_n;
    if (track) begin
      e.acc   = acc;
      e.delay = dly;
      e.rdata = exp_rd;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned acc, input int unsigned n);
    while (edge_n < acc + n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  int unsigned acc, acc2;

  initial begin
    repeat (4) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_spi_clk", spi_clk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xA5 to addr 5
    do_start(1'b1, 3'd5, 8'hA5, 8'h00, 0, 1'b1, acc);
    wait_cyc(acc, 1);
    check("wr_cs_fall", spi_cs_n, 1'b0);
    check("wr_busy_rise", busy, 1'b1);
    check("wr_first_mosi", spi_mosi, 1'b1);
    wait_cyc(acc, CS_RISE - 1);
    check("wr_cs_low_last", spi_cs_n, 1'b0);
    wait_cyc(acc, CS_RISE);
    check("wr_cs_rise", spi_cs_n, 1'b1);
    check("wr_busy_gap", busy, 1'b1);
    wait_cyc(acc, DONE_LAT + 1);
    check("wr_done_pulse", done, 1'b0);
    check("wr_done_seen", sb_q.size(), 0);
    check("wr_frame", tgt_last, 16'h85A5);
    check("wr_edges", tgt_edges, 16);
    check("wr_count", tgt_wr, 1);
    repeat (3) @(negedge clk);

    // Read addr 3, with an ignored start pulse mid-frame
    do_start(1'b0, 3'd3, 8'h00, 8'h3C, 0, 1'b1, acc);
    wait_cyc(acc, 50);
    rw = 1'b1; addr = 3'd7; wdata = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(acc, DONE_LAT + 12);
    check("rd_done_seen", sb_q.size(), 0);
    check("rd_cs_idle", spi_cs_n, 1'b1);
    check("rd_busy_idle", busy, 1'b0);
    check("rd_frame", tgt_last, 16'h0300);
    check("rd_frames", tgt_frames, 2);
    check("rd_no_write", tgt_wr, 1);
    check("rd_rdata_hold", rdata, 8'h3C);

    // Write 0x96 to addr 4 with ena low for 20 cycles mid-SHIFT
    do_start(1'b1, 3'd4, 8'h96, 8'h3C, 20, 1'b1, acc);
    wait_cyc(acc, 60);
    ena = 1'b0;
    wait_cyc(acc, 70);
    check("frz_spi_clk_mid", spi_clk, 1'b0);
    check("frz_cs_mid", spi_cs_n, 1'b0);
    wait_cyc(acc, 80);
    check("frz_spi_clk_end", spi_clk, 1'b0);
    check("frz_busy", busy, 1'b1);
    ena = 1'b1;
    wait_cyc(acc, 81);
    check("frz_resume_rise", spi_clk, 1'b1);
    wait_cyc(acc, DONE_LAT + 22);
    check("frz_done_seen", sb_q.size(), 0);
    check("frz_frame", tgt_last, 16'h8496);
    check("frz_edges", tgt_edges, 16);

    // Reset while bit 10 is on the wire: a write of 0xFF to addr 2 is aborted
    do_start(1'b1, 3'd2, 8'hFF, 8'h00, 0, 1'b0, acc);
    wait_cyc(acc, 78);
    rstb = 1'b0;
    wait_cyc(acc, 79);
    check("abort_cs_n", spi_cs_n, 1'b1);
    check("abort_spi_clk", spi_clk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_edges", tgt_edges, 10);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    // Read addr 2 after the abort
    do_start(1'b0, 3'd2, 8'h00, 8'h5A, 0, 1'b1, acc);
    wait_cyc(acc, DONE_LAT + 2);
    check("rd2_done_seen", sb_q.size(), 0);
    check("rd2_frames", tgt_frames, 4);

    // Back-to-back: write 0x11 to addr 1, then read it in the done cycle
    do_start(1'b1, 3'd1, 8'h11, 8'h5A, 0, 1'b1, acc);
    wait_cyc(acc, DONE_LAT);
    do_start(1'b0, 3'd1, 8'h00, 8'h11, 0, 1'b1, acc2);
    check("b2b_acc", acc2, acc + DONE_LAT);
    check("b2b_cs_fall", spi_cs_n, 1'b0);
    wait_cyc(acc2, DONE_LAT + 2);
    check("b2b_done_seen", sb_q.size(), 0);
    check("b2b_frame", tgt_last, 16'h0100);
    check("b2b_frames", tgt_frames, 6);
    check("b2b_writes", tgt_wr, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
